logic_capture_core: RTL and testbench
=====================================

Name: logic_capture_core

Overview:
Parametrised multi-channel logic-analyser capture engine. It succeeds the fixed 5-channel/60-step shift-register capture in the analyser top level. It samples `din` on a single-cycle `sample_en` strobe (the synchronised, edge-detected external sample clock) into a circular buffer. It supports selectable trigger modes and a programmable pre-trigger depth. The display state machine reads the result through a 1-cycle-latency random-access port, in chronological order.

Parameters:
CHANNELS, 5, number of captured logic channels (1..16)
DEPTH, 60, samples stored per capture (2..1024; need not be a power of two)
ADDR_W, 6, width of read address; must satisfy 2**ADDR_W >= DEPTH
PRETRIG, 3, samples kept before the trigger sample (0 <= PRETRIG < DEPTH)
CH_W, 3, width of trigger channel select; must satisfy 2**CH_W >= CHANNELS

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
sample_en  in  1  one-cycle strobe: sample `din` this cycle
din  in  CHANNELS  logic inputs, already synchronised to clk
arm  in  1  one-cycle pulse: start a capture (honoured only in IDLE or DONE)
abort  in  1  return to IDLE at once; buffer contents undefined
trig_mode  in  2  0 immediate, 1 any edge, 2 rising edge, 3 pattern match
trig_chan  in  CH_W  channel used by modes 1 and 2
trig_pattern  in  CHANNELS  match value for mode 3
trig_mask  in  CHANNELS  mode 3 compare mask; 1 = compare this bit
busy  out  1  high in PREFILL, ARMED and POST
done  out  1  sticky: capture complete, buffer valid
triggered  out  1  pulse on the clk cycle of the trigger sample write
rd_addr  in  ADDR_W  chronological index; 0 = oldest, PRETRIG = trigger sample
rd_data  out  CHANNELS  registered read data

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. busy=0, done=0, triggered=0, rd_data=0. Write pointer, counters and previous-sample register are cleared. Reset mid-capture abandons the capture.
- Config inputs (trig_*) are latched on the `arm` cycle and held for the whole capture.
- States:
  - IDLE: wait for `arm`.
  - `arm` → PREFILL; clear pre-count and prev_valid.
  - PREFILL: each `sample_en` writes `din` to buf[wp], advances wp (wraps DEPTH-1→0) and increments pre-count. When pre-count == PRETRIG, go to ARMED. If PRETRIG=0, `arm` goes directly to ARMED.
  - ARMED: each `sample_en` evaluates the trigger on the current `din`.
    - No hit: write the sample, advance wp, stay (pre-trigger window rolls).
    - Hit: write the sample, record ta=wp, pulse `triggered`, post-count=1, go to POST.
  - POST: each `sample_en` writes and increments post-count. When post-count reaches DEPTH-PRETRIG, go to DONE; `done`=1 and `busy`=0 from the next cycle.
  - DONE: hold until `arm` (→PREFILL, `done` clears on the same edge) or `abort`.
- Trigger rules:
  - Mode 0: the first ARMED sample hits.
  - Mode 1: din[trig_chan] != prev[trig_chan].
  - Mode 2: din[trig_chan] & ~prev[trig_chan].
  - Mode 3: ((din ^ trig_pattern) & trig_mask) == 0; mask=0 hits immediately.
  - Edge modes need prev_valid. The first sample after `arm` never edge-triggers.
  - prev updates on every `sample_en` while busy.
  - A trig_chan value >= CHANNELS never triggers.
- Read:
  - Physical address = (ta - PRETRIG + rd_addr) mod DEPTH, computed without a divider: conditional add or subtract of DEPTH.
  - rd_data is valid one clk after rd_addr.
  - rd_addr >= DEPTH returns 0.
  - Reads in any state other than DONE return undefined data, and have no side effects.
- Precedence in the same cycle: rst_n > abort > arm > sample_en. `arm` while busy is ignored. `abort` in IDLE is a no-op.
- No buffer overflow is possible: exactly DEPTH samples are retained, and earlier pre-trigger samples are overwritten.

Optional Feature:
LOGIC_CAPTURE_AUTOTRIG_EN:
- When defined: adds parameter AUTO_SAMPLES (default 1000) and output `auto_trig` (sticky until the next `arm`).
- If ARMED sees AUTO_SAMPLES consecutive `sample_en` without a hit, the next sample is force-triggered as in mode 0 and `auto_trig`=1.
- When undefined: no counter, no port; ARMED waits indefinitely.

Test Plan:
All scenarios use CHANNELS=4, DEPTH=8, PRETRIG=3, sample_en every 3rd clk.
1. Immediate: mode 0, arm, din = 1..12 → triggered on sample 4 (value 4). done after sample 8. rd_addr 0..7 → 1..8. rd_data valid 1 clk after rd_addr.
2. Rising edge: mode 2, chan 1, din = 0,0,0,0,0,0,2,2,0,2 → trigger on sample 7. Reads return 0,0,0,2,2,0,2,x (x = the 11th sample; supply 3 → read 3). Also: din=2 as the first sample must not trigger.
3. Pattern: mode 3, pattern=4'b1010, mask=4'b1110, din counts 0..15 → trigger on value 10 (4'b1010; 11 matches too but comes later). Reads 7..14.
4. Wrap: mode 1, chan 0, din held 0 for 20 samples, then 1 → pre-trigger samples read as 0,0,0. Trigger reads 1 with wp wrapped at least twice. done after 5 post samples.
5. abort in POST and rst_n=0 in ARMED → busy=0, done=0 next cycle. A following arm with mode 0 completes normally. arm while busy is ignored (done timing unchanged).
6. LOGIC_CAPTURE_AUTOTRIG_EN, AUTO_SAMPLES=5, mode 2, din constant 0 → forced trigger on the 6th ARMED sample. auto_trig=1, done follows.

Source files
------------

// File: rtl/logic_capture_core.sv
// Multi-channel logic-analyser capture engine: circular sample buffer with pre-trigger window,
// four trigger modes and a chronological 1-cycle read port. Optional LOGIC_CAPTURE_AUTOTRIG_EN adds a forced trigger.
module logic_capture_core #(
  parameter int CHANNELS = 5,
  parameter int DEPTH    = 60,
  parameter int ADDR_W   = 6,
  parameter int PRETRIG  = 3,
  parameter int CH_W     = 3
`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
  , parameter int AUTO_SAMPLES = 1000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] din,
  input  logic                arm,
  input  logic                abort,
  input  logic [1:0]          trig_mode,
  input  logic [CH_W-1:0]     trig_chan,
  input  logic [CHANNELS-1:0] trig_pattern,
  input  logic [CHANNELS-1:0] trig_mask,
  output logic                busy,
  output logic                done,
  output logic                triggered,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [CHANNELS-1:0] rd_data
`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
  , output logic              auto_trig
`endif
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] WP_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CW-1:0]     PRE_N   = CW'(PRETRIG);
  localparam logic [CW-1:0]     POST_N  = CW'(DEPTH - PRETRIG);
  localparam logic [CW-1:0]     DEPTH_N = CW'(DEPTH);
  localparam logic [CH_W:0]     CH_N    = (CH_W + 1)'(CHANNELS);

  typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_ARMED, S_POST, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CHANNELS-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]   wp_q, ta_q;
  logic [CW-1:0]       pre_q, post_q;
  logic [CHANNELS-1:0] prev_q, pat_q, mask_q, rd_data_q;
  logic                prev_vld_q;
  logic [1:0]          mode_q;
  logic [CH_W-1:0]     chan_q;

  logic                wr_en, ld_cfg, trig_fire, raw_hit, hit, force_hit, chan_ok;
  logic [CHANNELS-1:0] cur_sh, prv_sh;
  logic [CW-1:0]       ta_ext, base, sum, phys;

  always_comb begin
    chan_ok = {1'b0, chan_q} < CH_N;
    cur_sh  = din >> chan_q;
    prv_sh  = prev_q >> chan_q;
    case (mode_q)
      2'd0:    raw_hit = 1'b1;
      2'd1:    raw_hit = prev_vld_q & chan_ok & (cur_sh[0] ^ prv_sh[0]);
      2'd2:    raw_hit = prev_vld_q & chan_ok & cur_sh[0] & ~prv_sh[0];
      default: raw_hit = ((din ^ pat_q) & mask_q) == '0;
    endcase
    hit = raw_hit | force_hit;
  end

`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
  localparam int AW = $clog2(AUTO_SAMPLES + 1);
  localparam logic [AW-1:0] AUTO_N = AW'(AUTO_SAMPLES);
  logic [AW-1:0] auto_cnt_q;
  logic          auto_trig_q;
  assign force_hit = (auto_cnt_q == AUTO_N);
  assign auto_trig = auto_trig_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
    end else if (ld_cfg) begin
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
    end else if (state_q == S_ARMED && wr_en) begin
      if (!hit) auto_cnt_q <= auto_cnt_q + 1'b1;
      if (force_hit && !raw_hit) auto_trig_q <= 1'b1;
    end
  end
`else
  assign force_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    ld_cfg    = 1'b0;
    trig_fire = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (arm) begin
          ld_cfg  = 1'b1;
          state_d = (PRETRIG == 0) ? S_ARMED : S_PREFILL;
        end
        S_PREFILL: if (sample_en) begin
          wr_en = 1'b1;
          if (pre_q + 1'b1 == PRE_N) state_d = S_ARMED;
        end
        S_ARMED: if (sample_en) begin
          wr_en = 1'b1;
          if (hit) begin
            trig_fire = 1'b1;
            state_d   = (POST_N == CW'(1)) ? S_DONE : S_POST;
          end
        end
        S_POST: if (sample_en) begin
          wr_en = 1'b1;
          if (post_q + 1'b1 == POST_N) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Oldest sample sits PRETRIG slots behind the trigger; both wraps are a single add/subtract.
  always_comb begin
    ta_ext = {1'b0, ta_q};
    base   = (ta_ext >= PRE_N) ? ta_ext - PRE_N : ta_ext + DEPTH_N - PRE_N;
    sum    = base + {1'b0, rd_addr};
    phys   = (sum >= DEPTH_N) ? sum - DEPTH_N : sum;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      ta_q       <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      mode_q     <= '0;
      chan_q     <= '0;
      pat_q      <= '0;
      mask_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= ({1'b0, rd_addr} < DEPTH_N) ? mem_q[phys[ADDR_W-1:0]] : '0;
      if (ld_cfg) begin
        mode_q     <= trig_mode;
        chan_q     <= trig_chan;
        pat_q      <= trig_pattern;
        mask_q     <= trig_mask;
        pre_q      <= '0;
        post_q     <= '0;
        prev_vld_q <= 1'b0;
      end
      if (wr_en) begin
        wp_q       <= (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
        prev_q     <= din;
        prev_vld_q <= 1'b1;
        if (state_q == S_PREFILL) pre_q <= pre_q + 1'b1;
        if (state_q == S_POST) post_q <= post_q + 1'b1;
      end
      if (trig_fire) begin
        ta_q   <= wp_q;
        post_q <= CW'(1);
      end
    end
  end

  assign busy      = (state_q == S_PREFILL) || (state_q == S_ARMED) || (state_q == S_POST);
  assign done      = (state_q == S_DONE);
  assign triggered = trig_fire & rst_n;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_logic_capture_core.sv
// Bench for logic_capture_core: directed and random captures against a sample-history model.
`timescale 1ns/1ps
module tb_logic_capture_core;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 8;
  localparam int ADDR_W   = 4;
  localparam int PRETRIG  = 3;
  localparam int CH_W     = 2;
`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
  localparam int AUTO = 5;
`endif

  logic clk = 1'b0;
  logic rst_n, sample_en, arm, abort, busy, done, triggered;
  logic [CHANNELS-1:0] din, trig_pattern, trig_mask, rd_data;
  logic [1:0] trig_mode;
  logic [CH_W-1:0] trig_chan;
  logic [ADDR_W-1:0] rd_addr;
`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
  logic auto_trig;
`endif

  int checks = 0;
  int failures = 0;
  logic [3:0] smp[$];

  always #5 clk = ~clk;

  logic_capture_core #(
    .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .CH_W(CH_W)
`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
    , .AUTO_SAMPLES(AUTO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_chan(trig_chan), .trig_pattern(trig_pattern),
    .trig_mask(trig_mask), .busy(busy), .done(done), .triggered(triggered),
    .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
    , .auto_trig(auto_trig)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Trigger index in smp[] from the trigger rules; the first PRETRIG samples are pre-fill only.
  function automatic int model_trig(input int mode, input int chan, input logic [3:0] pat,
                                    input logic [3:0] mask, output bit forced);
    int misses = 0;
    forced = 0;
    for (int i = PRETRIG; i < smp.size(); i++) begin
      bit h;
      logic [3:0] c, p;
      c = smp[i];
      p = (i > 0) ? smp[i-1] : 4'h0;
      case (mode)
        0: h = 1;
        1: h = (i > 0) && (c[chan] != p[chan]);
        2: h = (i > 0) && c[chan] && !p[chan];
        default: h = ((c ^ pat) & mask) == 4'h0;
      endcase
`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
      if (!h && misses == AUTO) begin
        h = 1;
        forced = 1;
      end
`endif
      if (h) return i;
      misses++;
    end
    return -1;
  endfunction

  task automatic feed(input logic [3:0] v);
    din = v;
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_arm(input int mode, input int chan, input logic [3:0] pat, input logic [3:0] mask);
    trig_mode = mode[1:0];
    trig_chan = chan[1:0];
    trig_pattern = pat;
    trig_mask = mask;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic run_cap(input int mode, input int chan, input logic [3:0] pat, input logic [3:0] mask,
                         input int arm_at, input string tag);
    int t, last;
    bit forced, got_done;
    t = model_trig(mode, chan, pat, mask, forced);
    last = (t >= 0) ? t + DEPTH - PRETRIG - 1 : -1;
    got_done = 0;
    pulse_arm(mode, chan, pat, mask);
    check({tag, "/busy_after_arm"}, busy, 1);
    check({tag, "/done_after_arm"}, done, 0);
    for (int i = 0; i < smp.size(); i++) begin
      logic trg;
      din = smp[i];
      sample_en = 1'b1;
      arm = (i == arm_at);
      @(negedge clk);
      trg = triggered;
      step();
      sample_en = 1'b0;
      arm = 1'b0;
      check($sformatf("%s/trig%0d", tag, i), trg, (i == t));
      check($sformatf("%s/done%0d", tag, i), done, (i == last));
      if (done === 1'b1) begin
        got_done = 1;
        break;
      end
      step();
      step();
    end
    if (!got_done) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      return;
    end
    check({tag, "/busy_done"}, busy, 0);
`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
    check({tag, "/auto_trig"}, auto_trig, forced);
`endif
    for (int k = 0; k < 16; k++) begin
      rd_addr = k[ADDR_W-1:0];
      step();
      check($sformatf("%s/rd%0d", tag, k), rd_data, (k < DEPTH) ? smp[t - PRETRIG + k] : 4'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; arm = 1'b0; abort = 1'b0; din = '0;
    trig_mode = '0; trig_chan = '0; trig_pattern = '0; trig_mask = '0; rd_addr = '0;
    step();
    step();
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/triggered", triggered, 0);
    check("reset/rd_data", rd_data, 0);
    rst_n = 1'b1;
    step();

    smp = {};
    for (int i = 1; i <= 12; i++) smp.push_back(i[3:0]);
    run_cap(0, 0, 4'h0, 4'h0, -1, "immediate");

    smp = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd2, 4'd0, 4'd2, 4'd3};
    run_cap(2, 1, 4'h0, 4'h0, -1, "rising");

    smp = {4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    run_cap(2, 1, 4'h0, 4'h0, -1, "rising_held");

    smp = {};
    for (int i = 0; i < 16; i++) smp.push_back(i[3:0]);
    run_cap(3, 0, 4'b1010, 4'b1110, -1, "pattern");

    smp = {};
    for (int i = 0; i < 20; i++) smp.push_back(4'h0);
    for (int i = 0; i < 5; i++) smp.push_back(4'h1);
    run_cap(1, 0, 4'h0, 4'h0, -1, "wrap");

    smp = {};
    for (int i = 0; i < 10; i++) smp.push_back(4'(i + 5));
    run_cap(3, 0, 4'h5, 4'h0, -1, "mask_zero");

    pulse_arm(0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) feed(4'(i));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_post/busy", busy, 0);
    check("abort_post/done", done, 0);

    pulse_arm(2, 0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) feed(4'h0);
    rst_n = 1'b0;
    step();
    check("rst_armed/busy", busy, 0);
    check("rst_armed/done", done, 0);
    check("rst_armed/rd_data", rd_data, 0);
    rst_n = 1'b1;
    step();

    smp = {};
    for (int i = 0; i < 12; i++) smp.push_back(4'(15 - i));
    run_cap(0, 0, 4'h0, 4'h0, 5, "arm_while_busy");

`ifdef LOGIC_CAPTURE_AUTOTRIG_EN
    smp = {};
    for (int i = 0; i < 16; i++) smp.push_back(4'h0);
    run_cap(2, 0, 4'h0, 4'h0, -1, "autotrig");
`endif

    for (int r = 0; r < 8; r++) begin
      smp = {};
      for (int i = 0; i < 30; i++) smp.push_back(4'($urandom_range(0, 15)));
      run_cap(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), -1, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
